// File: rtl/rf_bank.sv
// rf_bank: parametrised register file, one write port and two registered read ports
// with range checking. Define RF_BYPASS_EN to forward same-edge write data to reads.
module rf_bank #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err,
    input  logic              rd0_en,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic [DATA_W-1:0] rd0_data,
    output logic              rd0_vld,
    output logic              rd0_err,
    input  logic              rd1_en,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd1_vld,
    output logic              rd1_err
);

    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

    // Out-of-range addresses never alias: the comparison is done at full integer width.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return (int'(addr) < DEPTH);
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              wr_ok_s;
    logic              rd0_ok_s;
    logic              rd1_ok_s;
    logic [DATA_W-1:0] rd0_mem_s;
    logic [DATA_W-1:0] rd1_mem_s;
    logic [DATA_W-1:0] rd0_next_s;
    logic [DATA_W-1:0] rd1_next_s;

    logic [DATA_W-1:0] rd0_data_r;
    logic [DATA_W-1:0] rd1_data_r;
    logic              rd0_vld_r;
    logic              rd1_vld_r;
    logic              rd0_err_r;
    logic              rd1_err_r;
    logic              wr_err_r;

    // Request qualification against the implemented depth.
    always_comb begin
        wr_ok_s  = wr_en && addr_in_range(wr_addr);
        rd0_ok_s = addr_in_range(rd0_addr);
        rd1_ok_s = addr_in_range(rd1_addr);
    end

    // Read multiplexers over the implemented entries only.
    always_comb begin
        rd0_mem_s = ZERO_DATA;
        rd1_mem_s = ZERO_DATA;
        for (int i = 0; i < DEPTH; i++) begin
            rd0_mem_s = (rd0_addr == ADDR_W'(i)) ? mem_r[i] : rd0_mem_s;
            rd1_mem_s = (rd1_addr == ADDR_W'(i)) ? mem_r[i] : rd1_mem_s;
        end
    end

    // Next read data: zero when out of range, optionally forwarded from the write port.
    always_comb begin
        rd0_next_s = ZERO_DATA;
        rd1_next_s = ZERO_DATA;
`ifdef RF_BYPASS_EN
        if (!rd0_ok_s) begin
            rd0_next_s = ZERO_DATA;
        end else if (wr_ok_s && (rd0_addr == wr_addr)) begin
            rd0_next_s = wr_data;
        end else begin
            rd0_next_s = rd0_mem_s;
        end
        if (!rd1_ok_s) begin
            rd1_next_s = ZERO_DATA;
        end else if (wr_ok_s && (rd1_addr == wr_addr)) begin
            rd1_next_s = wr_data;
        end else begin
            rd1_next_s = rd1_mem_s;
        end
`else
        if (rd0_ok_s) begin
            rd0_next_s = rd0_mem_s;
        end else begin
            rd0_next_s = ZERO_DATA;
        end
        if (rd1_ok_s) begin
            rd1_next_s = rd1_mem_s;
        end else begin
            rd1_next_s = ZERO_DATA;
        end
`endif
    end

    // Storage array: cleared by reset, written only for in-range addresses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= ZERO_DATA;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ok_s && (wr_addr == ADDR_W'(i))) begin
                    mem_r[i] <= wr_data;
                end
            end
        end
    end

    // Write error pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_err_r <= 1'b0;
        end else begin
            wr_err_r <= wr_en && !wr_ok_s;
        end
    end

    // Read port 0 output registers; data holds while the port is idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd0_data_r <= ZERO_DATA;
            rd0_vld_r  <= 1'b0;
            rd0_err_r  <= 1'b0;
        end else if (rd0_en) begin
            rd0_data_r <= rd0_next_s;
            rd0_vld_r  <= 1'b1;
            rd0_err_r  <= !rd0_ok_s;
        end else begin
            rd0_vld_r  <= 1'b0;
            rd0_err_r  <= 1'b0;
        end
    end

    // Read port 1 output registers; data holds while the port is idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd1_data_r <= ZERO_DATA;
            rd1_vld_r  <= 1'b0;
            rd1_err_r  <= 1'b0;
        end else if (rd1_en) begin
            rd1_data_r <= rd1_next_s;
            rd1_vld_r  <= 1'b1;
            rd1_err_r  <= !rd1_ok_s;
        end else begin
            rd1_vld_r  <= 1'b0;
            rd1_err_r  <= 1'b0;
        end
    end

    assign wr_err   = wr_err_r;
    assign rd0_data = rd0_data_r;
    assign rd0_vld  = rd0_vld_r;
    assign rd0_err  = rd0_err_r;
    assign rd1_data = rd1_data_r;
    assign rd1_vld  = rd1_vld_r;
    assign rd1_err  = rd1_err_r;

endmodule

// File: tb/tb_rf_bank.sv
// Self-checking bench for rf_bank: a full-depth instance and a DEPTH=6 instance share stimulus
// and are compared against an array-based reference model, plus table vectors and corner sequences.
module tb_rf_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, wr_en, rd0_en, rd1_en;
    logic [2:0] wr_addr, rd0_addr, rd1_addr;
    logic [7:0] wr_data;

    logic [7:0] a_rd0_data, a_rd1_data, b_rd0_data, b_rd1_data;
    logic       a_rd0_vld, a_rd0_err, a_rd1_vld, a_rd1_err, a_wr_err;
    logic       b_rd0_vld, b_rd0_err, b_rd1_vld, b_rd1_err, b_wr_err;

    rf_bank #(.DATA_W(8), .ADDR_W(3), .DEPTH(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(a_wr_err),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(a_rd0_data), .rd0_vld(a_rd0_vld), .rd0_err(a_rd0_err),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(a_rd1_data), .rd1_vld(a_rd1_vld), .rd1_err(a_rd1_err)
    );

    rf_bank #(.DATA_W(8), .ADDR_W(3), .DEPTH(6)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(b_wr_err),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(b_rd0_data), .rd0_vld(b_rd0_vld), .rd0_err(b_rd0_err),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(b_rd1_data), .rd1_vld(b_rd1_vld), .rd1_err(b_rd1_err)
    );

`ifdef RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
    localparam logic [7:0] COLL = 8'hE7;
`else
    localparam bit BYPASS = 1'b0;
    localparam logic [7:0] COLL = 8'h5C;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: index 0 = DEPTH 8 instance, index 1 = DEPTH 6 instance.
    logic [7:0] mm [2][8];
    logic [7:0] ed0 [2];
    logic [7:0] ed1 [2];
    logic       ev0 [2];
    logic       ee0 [2];
    logic       ev1 [2];
    logic       ee1 [2];
    logic       ewe [2];

    typedef struct {
        logic       rst_n;
        logic       wr_en;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       r0e;
        logic [2:0] r0a;
        logic       r1e;
        logic [2:0] r1a;
        logic [7:0] d0;
        logic       v0;
        logic       e0;
        logic [7:0] d1;
        logic       v1;
        logic       e1;
        logic       we;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic we_i, input logic [2:0] wa, input logic [7:0] wd,
                                input logic r0e, input logic [2:0] r0a, input logic r1e, input logic [2:0] r1a,
                                input logic [7:0] d0, input logic v0, input logic e0,
                                input logic [7:0] d1, input logic v1, input logic e1, input logic we);
        vec_t v;
        v.rst_n = r;   v.wr_en = we_i; v.wa = wa;   v.wd = wd;
        v.r0e   = r0e; v.r0a   = r0a;  v.r1e = r1e; v.r1a = r1a;
        v.d0 = d0; v.v0 = v0; v.e0 = e0; v.d1 = d1; v.v1 = v1; v.e1 = e1; v.we = we;
        return v;
    endfunction

    function automatic int depth_of(input int d);
        return (d == 0) ? 8 : 6;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply the specification's rules to the inputs present at this edge.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int dep;
            bit wr_hit;
            dep = depth_of(d);
            if (!rst_n) begin
                for (int a = 0; a < 8; a++) mm[d][a] = 8'h00;
                ed0[d] = 8'h00; ed1[d] = 8'h00;
                ev0[d] = 1'b0; ee0[d] = 1'b0; ev1[d] = 1'b0; ee1[d] = 1'b0; ewe[d] = 1'b0;
            end else begin
                wr_hit = wr_en && (int'(wr_addr) < dep);
                ev0[d] = rd0_en;
                ee0[d] = rd0_en && (int'(rd0_addr) >= dep);
                if (rd0_en) begin
                    if (int'(rd0_addr) >= dep) ed0[d] = 8'h00;
                    else if (BYPASS && wr_hit && wr_addr == rd0_addr) ed0[d] = wr_data;
                    else ed0[d] = mm[d][rd0_addr];
                end
                ev1[d] = rd1_en;
                ee1[d] = rd1_en && (int'(rd1_addr) >= dep);
                if (rd1_en) begin
                    if (int'(rd1_addr) >= dep) ed1[d] = 8'h00;
                    else if (BYPASS && wr_hit && wr_addr == rd1_addr) ed1[d] = wr_data;
                    else ed1[d] = mm[d][rd1_addr];
                end
                ewe[d] = wr_en && !wr_hit;
                if (wr_hit) mm[d][wr_addr] = wr_data;
            end
        end
    endtask

    function automatic logic [31:0] pack(input logic [7:0] d0, input logic v0, input logic e0,
                                         input logic [7:0] d1, input logic v1, input logic e1, input logic we);
        return {13'd0, d0, v0, e0, d1, v1, e1, we};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_depth8", pack(a_rd0_data, a_rd0_vld, a_rd0_err, a_rd1_data, a_rd1_vld, a_rd1_err, a_wr_err),
            pack(ed0[0], ev0[0], ee0[0], ed1[0], ev1[0], ee1[0], ewe[0]));
        chk("model_depth6", pack(b_rd0_data, b_rd0_vld, b_rd0_err, b_rd1_data, b_rd1_vld, b_rd1_err, b_wr_err),
            pack(ed0[1], ev0[1], ee0[1], ed1[1], ev1[1], ee1[1], ewe[1]));
    endtask

    task automatic drive(input vec_t v);
        rst_n = v.rst_n; wr_en = v.wr_en; wr_addr = v.wa; wr_data = v.wd;
        rd0_en = v.r0e; rd0_addr = v.r0a; rd1_en = v.r1e; rd1_addr = v.r1a;
    endtask

    task automatic idle();
        rst_n = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;
        rd0_en = 1'b0; rd0_addr = 3'd0; rd1_en = 1'b0; rd1_addr = 3'd0;
    endtask

    initial begin
        vec_t v;
        idle();
        rst_n = 1'b0;

        // Directed vectors with hand-derived expectations for the DEPTH 8 instance.
        tbl.push_back(mk(1'b0, 1'b1, 3'd2, 8'hAA, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 3'd2, 8'hAA, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1'b1, 1'b1, 3'(i), 8'((i + 1) * 17), 1'b0, 3'd0, 1'b0, 3'd0,
                             8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b1, 3'(7 - i),
                             8'((i + 1) * 17), 1'b1, 1'b0, 8'((8 - i) * 17), 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b0, 3'd0, 8'h22, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 3'd1, 8'h5A, 1'b0, 3'd0, 1'b0, 3'd0, 8'h22, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 3'd1, 8'h6B, 1'b0, 3'd0, 1'b0, 3'd0, 8'h22, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 3'd1, 8'h7C, 1'b0, 3'd0, 1'b0, 3'd0, 8'h22, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 3'd3, 8'h5C, 1'b0, 3'd0, 1'b0, 3'd0, 8'h22, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 3'd3, 8'hE7, 1'b1, 3'd3, 1'b1, 3'd3, COLL,  1'b1, 1'b0, COLL,  1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd3, 8'hE7, 1'b1, 1'b0, 8'hE7, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b0, 3'd0, 8'h11, 1'b1, 1'b0, 8'hE7, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));

        foreach (tbl[i]) begin
            v = tbl[i];
            drive(v);
            tick();
            chk($sformatf("vec%0d", i),
                pack(a_rd0_data, a_rd0_vld, a_rd0_err, a_rd1_data, a_rd1_vld, a_rd1_err, a_wr_err),
                pack(v.d0, v.v0, v.e0, v.d1, v.v1, v.e1, v.we));
        end

        // Range check on the DEPTH 6 instance: error pulse and no aliasing onto entries 0..5.
        for (int i = 0; i < 6; i++) begin
            idle(); wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'(8'h30 + i);
            tick();
        end
        idle(); wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'hFF;
        tick();
        chk("wr_err_pulse_d6", {31'd0, b_wr_err}, 32'd1);
        chk("wr_err_inrange_d8", {31'd0, a_wr_err}, 32'd0);
        idle();
        tick();
        chk("wr_err_clear_d6", {31'd0, b_wr_err}, 32'd0);
        idle(); rd1_en = 1'b1; rd1_addr = 3'd7;
        tick();
        chk("rd1_oor_d6", {22'd0, b_rd1_data, b_rd1_vld, b_rd1_err}, {22'd0, 8'h00, 1'b1, 1'b1});
        for (int i = 0; i < 6; i++) begin
            idle(); rd0_en = 1'b1; rd0_addr = 3'(i);
            tick();
            chk($sformatf("keep_d6_%0d", i), {24'd0, b_rd0_data}, {24'd0, 8'(8'h30 + i)});
        end

        // Randomised traffic with occasional resets, checked by the model on both instances.
        for (int n = 0; n < 3000; n++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = 3'($urandom_range(0, 7));
            wr_data  = 8'($urandom_range(0, 255));
            rd0_en   = 1'($urandom_range(0, 1));
            rd0_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
            rd1_en   = 1'($urandom_range(0, 1));
            rd1_addr = ($urandom_range(0, 3) == 0) ? rd0_addr : 3'($urandom_range(0, 7));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_bank.md
Name: rf_bank

Overview:
- Parametrised multi-bit register file; next generation of the single-bit register-file cell.
- One write port and two independent read ports with registered (1-cycle) read data.
- Read-valid/error handshake outputs and address range checking.
- Used as the general-purpose storage bank for the sequential-circuit datapaths.

Parameters:
- DATA_W, 8: width of each entry in bits.
- ADDR_W, 3: width of the address buses.
- DEPTH, 8: number of implemented entries. Must satisfy 1 <= DEPTH <= 2**ADDR_W. Addresses >= DEPTH are out of range.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- wr_en  input  1  write request.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- wr_err  output  1  one-cycle pulse: the previous-cycle write was out of range.
- rd0_en  input  1  read request, port 0.
- rd0_addr  input  ADDR_W  read address, port 0.
- rd0_data  output  DATA_W  registered read data, port 0.
- rd0_vld  output  1  one-cycle pulse: rd0_data updated.
- rd0_err  output  1  one-cycle pulse alongside rd0_vld: address was out of range.
- rd1_en, rd1_addr, rd1_data, rd1_vld, rd1_err: identical set for port 1.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset: at a rising edge with rst_n=0:
  - all DEPTH entries are set to 0;
  - rd0_data, rd1_data, rd0_vld, rd1_vld, rd0_err, rd1_err and wr_err are set to 0;
  - any write or read request in that cycle is ignored, so reset wins over every request.
- Reset mid-operation: a read issued in the cycle before reset still pulses vld in the reset cycle? No. Reset clears vld, so the pending result is dropped.
- Write, at an edge with rst_n=1 and wr_en=1:
  - if wr_addr < DEPTH: mem[wr_addr] <= wr_data and wr_err <= 0;
  - otherwise: memory is unchanged and wr_err <= 1 for exactly one cycle.
  - wr_err is 0 in any cycle following an edge with wr_en=0.
- Read, port k, at an edge with rst_n=1 and rdk_en=1:
  - rdk_vld <= 1;
  - if rdk_addr < DEPTH: rdk_data <= mem[rdk_addr] and rdk_err <= 0;
  - otherwise: rdk_data <= 0 and rdk_err <= 1.
  - Latency: data is presented in the cycle after the request edge.
- Read, port k, at an edge with rdk_en=0:
  - rdk_vld <= 0 and rdk_err <= 0;
  - rdk_data holds its last value.
- Back-to-back reads: one result per cycle per port, no bubbles.
- Both ports reading the same address in the same cycle return identical data.
- Read and write to the same in-range address at the same edge: the read returns the old (pre-write) contents, unless RF_BYPASS_EN is defined.
- Addresses never wrap: an out-of-range address never aliases onto an in-range entry.
- No X on any output after the first reset edge.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-to-read forwarding. When wr_en=1, wr_addr < DEPTH and rdk_en=1 with rdk_addr == wr_addr at the same edge, rdk_data <= wr_data (new value). The memory is written as normal. Each port forwards independently.
- Undefined: no forwarding; the read returns the old contents. Read-data logic has no path from wr_data.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with wr_en=1, wr_addr=2, wr_data=8'hAA → after release, reading address 2 gives rd0_data=8'h00, rd0_vld=1, rd0_err=0; all outputs were 0 during reset.
- Basic write/read: write 8'h11..8'h88 to addresses 0..7 on consecutive edges, then read 0..7 on port 0 and 7..0 on port 1 back-to-back → each port returns the correct value one cycle after each request; vld is high for 8 consecutive cycles.
- Same-address collision: mem[3]=8'h5C; at one edge write 8'hE7 to address 3 with rd0_addr=rd1_addr=3 → both ports return 8'h5C without RF_BYPASS_EN, 8'hE7 with it. A read of address 3 on the next edge returns 8'hE7 in both builds.
- Range check, with DEPTH=6 and ADDR_W=3: write 8'hFF to address 6 → wr_err pulses 1 cycle and entries 0..5 are unchanged. Read address 7 on port 1 → rd1_data=0, rd1_vld=1, rd1_err=1.
- Hold behaviour: read address 1 (=8'h22), then deassert rd0_en for 3 cycles while rewriting address 1 → rd0_data stays 8'h22, rd0_vld=0.
- Reset mid-read: rd0_en=1 at edge N, rst_n=0 at edge N+1 → after N+1 rd0_vld=0 and rd0_data=0.
